// File: rtl/load_extender.sv
// load_extender: load-path half/byte widening lanes with a one-cycle registered result
module load_extender (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] half_in,
   input  logic [1:0]  half_op,
   input  logic [7:0]  byte_in,
   input  logic        byte_isu,
   input  logic        sel_half,
   input  logic        en,
   output logic [31:0] half_out,
   output logic [31:0] byte_out,
   output logic [31:0] res_q,
   output logic        res_vld
);
   logic [31:0] res_d;
   // op 11 is reserved and deliberately folds into zero extension
   always_comb begin
      half_out = half_op == 2'b00 ? {{16{half_in[15]}}, half_in} :
                 half_op == 2'b10 ? {half_in, 16'h0000} : {16'h0000, half_in};
      byte_out = byte_isu ? {24'h0, byte_in} : {{24{byte_in[7]}}, byte_in};
      res_d    = en ? (sel_half ? half_out : byte_out) : res_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         res_q   <= '0;
         res_vld <= 1'b0;
      end else begin
         res_q   <= res_d;
         res_vld <= en;
      end
   end
endmodule

// File: tb/tb_load_extender.sv
// tb_load_extender: directed and sweep stimulus with a queue-based scoreboard on the registered path
module tb_load_extender;
   logic        clk = 1'b0;
   logic        reset = 1'b1, byte_isu = 1'b0, sel_half = 1'b0, en = 1'b0;
   logic [15:0] half_in = '0;
   logic [1:0]  half_op = '0;
   logic [7:0]  byte_in = '0;
   logic [31:0] half_out, byte_out, res_q;
   logic        res_vld;
   int          errors = 0, checks = 0;
   logic [32:0] sb[$];
   logic [31:0] m_res = '0;
   logic [32:0] x;

   always #5 clk = ~clk;

   load_extender dut (
      .clk(clk), .reset(reset), .half_in(half_in), .half_op(half_op),
      .byte_in(byte_in), .byte_isu(byte_isu), .sel_half(sel_half), .en(en),
      .half_out(half_out), .byte_out(byte_out), .res_q(res_q), .res_vld(res_vld)
   );

   function automatic logic [31:0] f_half(input logic [15:0] h, input logic [1:0] op);
      if (op == 2'b00) return {{16{h[15]}}, h};
      if (op == 2'b10) return {h, 16'h0000};
      return {16'h0000, h};
   endfunction

   function automatic logic [31:0] f_byte(input logic [7:0] b, input logic u);
      return u ? {24'h0, b} : {{24{b[7]}}, b};
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   // drives one cycle of inputs, queues the registered result expected after the next edge
   task automatic step(input logic r, input logic e, input logic s, input logic [15:0] h,
                       input logic [1:0] op, input logic [7:0] b, input logic u);
      logic v;
      @(posedge clk);
      #2;
      reset = r; en = e; sel_half = s; half_in = h; half_op = op; byte_in = b; byte_isu = u;
      if (r) begin
         m_res = '0;
         v = 1'b0;
      end else if (e) begin
         m_res = s ? f_half(h, op) : f_byte(b, u);
         v = 1'b1;
      end else v = 1'b0;
      sb.push_back({v, m_res});
      #1;
      chk("half_out", half_out, f_half(h, op));
      chk("byte_out", byte_out, f_byte(b, u));
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         x = sb.pop_front();
         chk("res_q", res_q, x[31:0]);
         chk("res_vld", {31'b0, res_vld}, {31'b0, x[32]});
      end
   end

   initial begin
      step(1, 0, 0, 16'h0, 2'b00, 8'h0, 0);
      step(1, 0, 0, 16'h0, 2'b00, 8'h0, 0);
      chk("reset_res_q", res_q, 32'h0);
      chk("reset_vld", {31'b0, res_vld}, 32'h0);
      step(0, 0, 0, 16'h8001, 2'b00, 8'hF0, 0);
      chk("h8001_op00", half_out, 32'hFFFF8001);
      chk("bF0_sign", byte_out, 32'hFFFFFFF0);
      step(0, 0, 0, 16'h8001, 2'b01, 8'hF0, 1);
      chk("h8001_op01", half_out, 32'h00008001);
      chk("bF0_zero", byte_out, 32'h000000F0);
      step(0, 0, 0, 16'h8001, 2'b10, 8'h7F, 0);
      chk("h8001_op10", half_out, 32'h80010000);
      chk("b7F_sign", byte_out, 32'h0000007F);
      step(0, 0, 0, 16'h8001, 2'b11, 8'h80, 0);
      chk("h8001_op11", half_out, 32'h00008001);
      chk("b80_sign", byte_out, 32'hFFFFFF80);
      step(0, 0, 0, 16'h8000, 2'b00, 8'hFF, 0);
      chk("h8000_sign", half_out, 32'hFFFF8000);
      chk("bFF_sign", byte_out, 32'hFFFFFFFF);
      step(0, 0, 0, 16'hFFFF, 2'b00, 8'hFF, 1);
      chk("hFFFF_sign", half_out, 32'hFFFFFFFF);
      chk("bFF_zero", byte_out, 32'h000000FF);
      step(0, 0, 0, 16'hFFFF, 2'b01, 8'h7F, 1);
      chk("hFFFF_zero", half_out, 32'h0000FFFF);
      chk("b7F_zero", byte_out, 32'h0000007F);
      step(0, 0, 0, 16'h7FFF, 2'b00, 8'h00, 0);
      chk("h7FFF_sign", half_out, 32'h00007FFF);
      step(0, 1, 1, 16'h1234, 2'b00, 8'hAA, 0);
      step(0, 0, 0, 16'h5555, 2'b10, 8'h55, 1);
      chk("cap_res_q", res_q, 32'h00001234);
      chk("cap_vld", {31'b0, res_vld}, 32'h1);
      step(0, 0, 1, 16'h9999, 2'b00, 8'h99, 0);
      chk("hold_res_q", res_q, 32'h00001234);
      chk("hold_vld", {31'b0, res_vld}, 32'h0);
      step(0, 1, 0, 16'hABCD, 2'b00, 8'h81, 0);
      step(1, 1, 1, 16'hFFFF, 2'b00, 8'hFF, 0);
      chk("pre_rst_res_q", res_q, 32'hFFFFFF81);
      step(0, 0, 0, 16'h0, 2'b00, 8'h0, 0);
      chk("rst_en_res_q", res_q, 32'h0);
      chk("rst_en_vld", {31'b0, res_vld}, 32'h0);
      for (int i = 0; i < 512; i++)
         step(0, 1, i[0], 16'(i * 16'h0101), 2'(i >> 1), 8'(i >> 1), i[8]);
      for (int i = 0; i < 256; i++)
         step(0, 1, i[1], 16'($urandom), 2'(i), 8'($urandom), i[2]);
      step(0, 0, 0, 16'h0, 2'b00, 8'h0, 0);
      @(posedge clk);
      #3;
      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
